// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-size codes and lane helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} lsu_state_e;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int LSU_TIMEOUT_DEFAULT = 16;
  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] lane);
    return size == SZ_BYTE ? 4'b0001 << lane : size == SZ_HALF ? 4'b0011 << {lane[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] d);
    return size == SZ_BYTE ? {4{d[7:0]}} : size == SZ_HALF ? {2{d[15:0]}} : d;
  endfunction
endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory req/gnt/rvalid bus between the load/store unit and memory
interface lsu_ctrl_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_in;
  logic        dmem_rvalid_in;
  logic [31:0] dmem_rdata_in;
  modport master (output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  input  dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in);
  modport slave  (input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  output dmem_gnt_in, dmem_rvalid_in, dmem_rdata_in);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half lane of read data and sign- or zero-extends it
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  output logic [31:0] o_data
);
  logic [7:0]  w_b;
  logic [15:0] w_h;
  assign w_b = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_h = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  assign o_data = i_size == SZ_BYTE ? {{24{~i_uns & w_b[7]}}, w_b} :
                  i_size == SZ_HALF ? {{16{~i_uns & w_h[15]}}, w_h} : i_rdata;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: sequences one load/store over the dmem req/gnt/rvalid bus and stalls the pipeline meanwhile.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of aligning them down.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              ld_in,
  input  logic              st_in,
  input  logic [1:0]        size_in,
  input  logic              unsigned_in,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  lsu_ctrl_if.master        dmem,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              bus_err_o,
  output logic              misalign_o
);
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  lsu_state_e  r_state;
  logic        r_req, r_we, r_uns, r_done, r_bus_err, r_misalign;
  logic [1:0]  r_size, r_lane;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_load_data;
  logic [1:0]  w_lane;
  logic [7:0]  w_cnt_nx;
  logic        w_tmo, w_trap;
  logic [31:0] w_fmt;
  // lane after aligning down; a trapped access never reaches the bus so its lane is irrelevant
  assign w_lane = size_in == SZ_BYTE ? addr_in[1:0] : size_in == SZ_HALF ? {addr_in[1], 1'b0} : 2'b00;
`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = (size_in == SZ_HALF && addr_in[0]) || (size_in == SZ_WORD && addr_in[1:0] != 2'b00);
`else
  assign w_trap = 1'b0;
`endif
  assign w_cnt_nx = r_cnt + 8'd1;
  assign w_tmo = w_cnt_nx == TMO;
  lsu_load_align u_align (
    .i_rdata (dmem.dmem_rdata_in),
    .i_lane  (r_lane),
    .i_size  (r_size),
    .i_uns   (r_uns),
    .o_data  (w_fmt)
  );
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= IDLE;
      r_req <= 1'b0;
      r_we <= 1'b0;
      r_uns <= 1'b0;
      r_size <= SZ_BYTE;
      r_lane <= 2'b00;
      r_addr <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_cnt <= '0;
      r_done <= 1'b0;
      r_load_data <= '0;
      r_bus_err <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (ld_in || st_in) begin
          r_we <= st_in;
          r_size <= size_in;
          r_uns <= unsigned_in;
          r_lane <= w_lane;
          r_addr <= {addr_in[31:2], 2'b00};
          r_be <= be_of(size_in, w_lane);
          r_wdata <= wdata_of(size_in, wdata_in);
          r_cnt <= '0;
          r_load_data <= '0;
          r_bus_err <= 1'b0;
          r_misalign <= w_trap;
          r_state <= w_trap ? DONE : REQ;
          r_done <= w_trap;
          r_req <= ~w_trap;
        end
        REQ: begin
          r_cnt <= w_cnt_nx;
          if (dmem.dmem_gnt_in) begin
            r_req <= 1'b0;
            r_cnt <= '0;
            r_state <= r_we ? DONE : WAIT;
            r_done <= r_we;
          end else if (w_tmo) begin
            r_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state <= DONE;
            r_done <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= w_cnt_nx;
          if (dmem.dmem_rvalid_in) begin
            r_load_data <= w_fmt;
            r_state <= DONE;
            r_done <= 1'b1;
          end else if (w_tmo) begin
            r_bus_err <= 1'b1;
            r_state <= DONE;
            r_done <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
  assign dmem.dmem_req_o = r_req;
  assign dmem.dmem_we_o = r_we;
  assign dmem.dmem_addr_o = r_addr;
  assign dmem.dmem_be_o = r_be;
  assign dmem.dmem_wdata_o = r_wdata;
  assign stall_o = (r_state == IDLE && (ld_in || st_in)) || r_state == REQ || r_state == WAIT;
  assign done_o = r_done;
  assign load_data_o = r_load_data;
  assign bus_err_o = r_bus_err;
  assign misalign_o = r_misalign;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the instruction decoder and the data-memory bus of the RV32 core. It accepts one decoded load or store at a time. It drives a req/gnt/rvalid memory handshake with lane-aligned byte enables and write data, then returns a sign- or zero-extended load result. It holds the pipeline stalled for the duration of each access.

## Interface
- TIMEOUT_CYCLES, 16, cycles allowed in REQ or WAIT before abort with bus error; legal range 2..255
- clk_in  input  1  core clock; all state changes on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- ld_in  input  1  decoded load, valid this cycle
- st_in  input  1  decoded store (decoder mem_wr_req), valid this cycle
- size_in  input  2  access size from funct3[13:12]: 00 byte, 01 half, 10 word, 11 reserved
- unsigned_in  input  1  zero-extend load result (funct3[14])
- addr_in  input  32  effective address from the immediate adder
- wdata_in  input  32  store data (rs2)
- dmem_req_o  output  1  bus request
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word-aligned address, bits [1:0] = 0
- dmem_be_o  output  4  byte enables
- dmem_wdata_o  output  32  lane-replicated store data
- dmem_gnt_in  input  1  request accepted
- dmem_rvalid_in  input  1  read data valid
- dmem_rdata_in  input  32  read data
- stall_o  output  1  freeze upstream pipeline
- done_o  output  1  one-cycle completion pulse
- load_data_o  output  32  formatted load result; valid when done_o = 1
- bus_err_o  output  1  timeout abort; valid when done_o = 1
- misalign_o  output  1  misaligned access; valid when done_o = 1

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: ld_in | st_in latches size, unsigned, addr, wdata and kind. If ld_in and st_in are both high, the store executes and the load is dropped. Next state is REQ, or DONE if the access is misaligned (see Configuration).
- REQ: dmem_req_o = 1. Address, we, be and wdata are held stable until dmem_gnt_in.
  - On gnt, a store goes to DONE and a load goes to WAIT.
- WAIT: on dmem_rvalid_in, rdata is captured, the result is formatted into a register, and the next state is DONE.
- DONE: done_o = 1 for exactly one cycle, then IDLE. ld_in and st_in are ignored in every state except IDLE.
- Byte enables: byte → 4'b0001 << addr[1:0]; half → 4'b0011 << {addr[1],1'b0}; word and reserved size → 4'b1111.
- wdata lanes: byte replicated ×4; half replicated ×2; word passed through.
- Load format: select lane by latched addr[1:0] (half by addr[1]); sign-extend unless unsigned_in. Word ignores unsigned_in.
- Timeout: 8-bit counter, cleared on entry to REQ and WAIT, increments each cycle in those states.
  - On reaching TIMEOUT_CYCLES: dmem_req_o drops, next state DONE, bus_err_o = 1, load_data_o = 0.
  - A gnt or rvalid in the same cycle as the counter reaching the limit wins; no error is raised.

## Timing
- Reset values: state IDLE; every output 0, including dmem_addr_o, dmem_be_o, dmem_wdata_o and load_data_o.
- Reset mid-access: immediate return to IDLE, dmem_req_o low asynchronously, no done_o pulse.
- stall_o = (IDLE & (ld_in | st_in)) | REQ | WAIT. It is combinational and 0 in DONE.
- Store with gnt in the first REQ cycle: start at t, req at t+1, done_o at t+2.
- Load with gnt at t+1 and rvalid at t+2: done_o at t+3.
- Each cycle without gnt or rvalid adds one cycle of latency.
- dmem_rvalid_in outside WAIT is ignored.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - A half at odd address, or a word with addr[1:0] ≠ 0, issues no bus request.
  - The access goes IDLE → DONE, with done_o at start + 1 and misalign_o = 1.
- Not defined:
  - misalign_o is tied 0.
  - Offending low address bits are forced to 0 (access aligned down) and the access proceeds normally.

## Structure
- Package lsu_pkg holds:
  - state enum (IDLE, REQ, WAIT, DONE);
  - size constants SZ_BYTE, SZ_HALF, SZ_WORD;
  - default timeout constant.
- Sub-module lsu_load_align: combinational lane select plus sign/zero extend (rdata, addr[1:0], size, unsigned → 32-bit result). It is instantiated once.

## Test plan
- Store byte: addr 0x1003, wdata 0xAB, gnt on the first REQ cycle → be 4'b1000, wdata 0xABABABAB, addr 0x1000, done_o at t+2.
- Load half signed: addr 0x2002, rdata 0x8001_1234, rvalid one cycle after gnt → load_data_o 0xFFFF8001 at t+3. Same access with unsigned_in → 0x00008001.
- Backpressure: gnt delayed 5 cycles → req, addr, be and wdata stable throughout; stall_o high until done_o.
- Timeout: no gnt → done_o with bus_err_o = 1 after TIMEOUT_CYCLES in REQ; req deasserted.
- Misaligned word at 0x3001, macro defined → no req, done_o at t+1, misalign_o = 1. Macro undefined → bus addr 0x3000, be 4'b1111.
- Reset asserted in WAIT → all outputs 0 immediately, no done_o. A new load after release completes normally.
